// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and access-legality helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StMerge,
    StWrite,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    SzB,
    SzH,
    SzW,
    SzD
  } size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  function automatic logic is_aligned(size_e size, logic [2:0] off);
    logic ok;
    unique case (size)
      SzB:     ok = 1'b1;
      SzH:     ok = (off[0] == 1'b0);
      SzW:     ok = (off[1:0] == 2'b00);
      default: ok = (off == 3'b000);
    endcase
    return ok;
  endfunction

  // Stores have no unsigned variants; load 111 would be an unsigned doubleword.
  function automatic logic f3_legal(logic is_store, logic [2:0] f3);
    return is_store ? ~f3[2] : (f3 != 3'b111);
  endfunction

endpackage

// File: rtl/lsu_mem_access_lane_align.sv
// Combinational lane steering: load extract/extend and store byte-mask merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  size_e       size_i,
  input  logic [2:0]  offset_i,
  input  logic        sign_i,
  input  logic [63:0] rdata_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] load_o,
  output logic [63:0] merge_o
);

  logic [63:0] shifted;
  logic [63:0] wshift;
  logic [7:0]  size_mask;
  logic [7:0]  lane_mask;

  always_comb begin
    shifted = rdata_i >> {offset_i, 3'b000};
    unique case (size_i)
      SzB:     load_o = {{56{sign_i & shifted[7]}}, shifted[7:0]};
      SzH:     load_o = {{48{sign_i & shifted[15]}}, shifted[15:0]};
      SzW:     load_o = {{32{sign_i & shifted[31]}}, shifted[31:0]};
      default: load_o = shifted;
    endcase
  end

  always_comb begin
    unique case (size_i)
      SzB:     size_mask = 8'h01;
      SzH:     size_mask = 8'h03;
      SzW:     size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    lane_mask = size_mask << offset_i;
    wshift    = wdata_i << {offset_i, 3'b000};
    merge_o   = rdata_i;
    for (int i = 0; i < 8; i++) begin
      if (lane_mask[i]) merge_o[8*i +: 8] = wshift[8*i +: 8];
    end
  end

endmodule

// File: rtl/lsu_mem_access.sv
// Load/store access FSM: sub-doubleword loads with extension, stores via read-modify-write.
module lsu_mem_access
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_RD_LATENCY = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        IsStore,
  input  logic [2:0]  Funct3,
  input  logic [63:0] Address,
  input  logic [63:0] StoreData,
  output logic        Busy,
  output logic        Done,
  output logic        Fault,
  output logic [63:0] LoadData,
  output logic [63:0] MemAddress,
  output logic [63:0] MemWrData,
  output logic        MemWr,
  input  logic [63:0] MemRdData
);

  localparam logic [1:0] CntInit = 2'(MEM_RD_LATENCY - 1);

  state_e      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [2:0]  f3_q, f3_d;
  logic        store_q, store_d;
  logic [63:0] sdata_q, sdata_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        fault_q, fault_d;
  logic [63:0] load_q, load_d;
  logic [63:0] wbuf_q, wbuf_d;

  logic        in_ok;
  logic [63:0] align_rdata;
  logic [63:0] align_load;
  logic [63:0] align_merge;

  assign in_ok = f3_legal(IsStore, Funct3) && is_aligned(size_e'(Funct3[1:0]), Address[2:0]);

  // The merge step works on the doubleword captured at the end of READ.
  assign align_rdata = (state_q == StMerge) ? wbuf_q : MemRdData;

  lsu_lane_align u_lane_align (
    .size_i   (size_e'(f3_q[1:0])),
    .offset_i (addr_q[2:0]),
    .sign_i   (~f3_q[2]),
    .rdata_i  (align_rdata),
    .wdata_i  (sdata_q),
    .load_o   (align_load),
    .merge_o  (align_merge)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    store_d = store_q;
    sdata_d = sdata_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    load_d  = load_q;
    wbuf_d  = wbuf_q;
    unique case (state_q)
      StIdle: begin
        if (Req) begin
          addr_d  = Address;
          f3_d    = Funct3;
          store_d = IsStore;
          sdata_d = StoreData;
          fault_d = ~in_ok;
          if (!in_ok) begin
            state_d = StDone;
          end else if (IsStore && (Funct3 == F3_D)) begin
            wbuf_d  = StoreData;
            state_d = StWrite;
          end else begin
            cnt_d   = CntInit;
            state_d = StRead;
          end
        end
      end
      StRead: begin
        if (cnt_q == 2'd0) begin
          if (store_q) begin
            wbuf_d  = MemRdData;
            state_d = StMerge;
          end else begin
            load_d  = align_load;
            state_d = StDone;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StMerge: begin
        wbuf_d  = align_merge;
        state_d = StWrite;
      end
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      f3_q    <= '0;
      store_q <= 1'b0;
      sdata_q <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      load_q  <= '0;
      wbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      store_q <= store_d;
      sdata_q <= sdata_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      load_q  <= load_d;
      wbuf_q  <= wbuf_d;
    end
  end

  // Strobes decode straight from state so an asynchronous reset kills MemWr at once.
  assign Busy       = (state_q != StIdle);
  assign Done       = (state_q == StDone);
  assign Fault      = Done & fault_q;
  assign MemWr      = (state_q == StWrite);
  assign MemAddress = Busy ? {addr_q[63:3], 3'b000} : 64'd0;
  assign MemWrData  = wbuf_q;
  assign LoadData   = load_q;

endmodule
